// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, grant owner,
// the fixed word access size used for instruction fetches, and a width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // Watchdog counter width: enough to hold TIMEOUT_CYCLES, never below one bit.
  function automatic int wd_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Saturating cycle counter that flags a memory transaction which has gone
// TIMEOUT_CYCLES cycles without completion. TIMEOUT_CYCLES = 0 disables it.
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = wd_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  // Count value at which the next un-acked cycle reaches the limit.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled and stick at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires in the cycle whose missing ack would bring the count to the limit.
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && !i_clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered req/ack memory port between the CPU instruction-fetch
// and load/store channels. Round-robin or data-first arbitration, response
// routing back to the granted requester, and a watchdog for hung transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_PRIORITY  = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_req,
  input  logic [XLEN-1:0] i_inst_addr,
  output logic            o_inst_ack,
  output logic [XLEN-1:0] o_inst_data,
  output logic            o_inst_err,
  input  logic            i_data_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_wdata,
  input  logic [2:0]      i_data_funct3,
  input  logic            i_data_we,
  output logic            o_data_ack,
  output logic [XLEN-1:0] o_data_rdata,
  output logic            o_data_err,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [2:0]      o_mem_funct3,
  output logic            o_mem_we,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  arb_state_e      state_q, state_d;
  gnt_e            gnt_q, gnt_d;
  gnt_e            rr_last_q, rr_last_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]      mem_funct3_q, mem_funct3_d;
  logic            mem_we_q, mem_we_d;
  logic            inst_ack_q, inst_ack_d;
  logic            inst_err_q, inst_err_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic            data_ack_q, data_ack_d;
  logic            data_err_q, data_err_d;
  logic [XLEN-1:0] data_rdata_q, data_rdata_d;

  logic pick_data;
  logic wd_clear, wd_enable, wd_expired;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (wd_clear),
    .i_enable (wd_enable),
    .o_expired(wd_expired)
  );

  // Next-state logic: arbitration in IDLE, completion/timeout in BUSY, ack pulse in RESP.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_last_d    = rr_last_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    mem_we_d     = mem_we_q;
    inst_ack_d   = 1'b0;
    inst_err_d   = 1'b0;
    inst_data_d  = inst_data_q;
    data_ack_d   = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    pick_data    = 1'b0;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (i_inst_req && i_data_req) begin
          pick_data = (DATA_PRIORITY != 0) ? 1'b1 : (rr_last_q == GNT_INST);
        end else begin
          pick_data = i_data_req;
        end
        if (i_inst_req || i_data_req) begin
          gnt_d     = pick_data ? GNT_DATA : GNT_INST;
          rr_last_d = pick_data ? GNT_DATA : GNT_INST;
          mem_req_d = 1'b1;
          wd_clear  = 1'b1;
          state_d   = ARB_BUSY;
          if (pick_data) begin
            mem_addr_d   = i_data_addr;
            mem_wdata_d  = i_data_wdata;
            mem_funct3_d = i_data_funct3;
            mem_we_d     = i_data_we;
          end else begin
            mem_addr_d   = i_inst_addr;
            mem_wdata_d  = '0;
            mem_funct3_d = FUNCT3_WORD;
            mem_we_d     = 1'b0;
          end
        end
      end
      ARB_BUSY: begin
        wd_enable = !i_mem_ack;
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (gnt_q == GNT_DATA) begin
            data_ack_d   = 1'b1;
            data_rdata_d = i_mem_rdata;
          end else begin
            inst_ack_d  = 1'b1;
            inst_data_d = i_mem_rdata;
          end
        end else if (wd_expired) begin
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (gnt_q == GNT_DATA) begin
            data_ack_d   = 1'b1;
            data_err_d   = 1'b1;
            data_rdata_d = '0;
          end else begin
            inst_ack_d  = 1'b1;
            inst_err_d  = 1'b1;
            inst_data_d = '0;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset lands in IDLE with everything cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ARB_IDLE;
      gnt_q        <= GNT_INST;
      rr_last_q    <= GNT_DATA;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      mem_we_q     <= 1'b0;
      inst_ack_q   <= 1'b0;
      inst_err_q   <= 1'b0;
      inst_data_q  <= '0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_last_q    <= rr_last_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      mem_we_q     <= mem_we_d;
      inst_ack_q   <= inst_ack_d;
      inst_err_q   <= inst_err_d;
      inst_data_q  <= inst_data_d;
      data_ack_q   <= data_ack_d;
      data_err_q   <= data_err_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_funct3 = mem_funct3_q;
  assign o_mem_we     = mem_we_q;
  assign o_inst_ack   = inst_ack_q;
  assign o_inst_err   = inst_err_q;
  assign o_inst_data  = inst_data_q;
  assign o_data_ack   = data_ack_q;
  assign o_data_err   = data_err_q;
  assign o_data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A (round-robin, 4-cycle watchdog) driven from a
// vector table plus corner-case sequences; instance B (data priority, watchdog off).
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_rst, a_inst_req, a_inst_ack, a_inst_err, a_data_req, a_data_we, a_data_ack, a_data_err;
  logic [31:0] a_inst_addr, a_inst_data, a_data_addr, a_data_wdata, a_data_rdata;
  logic [2:0]  a_data_f3, a_mem_f3;
  logic        a_mem_req, a_mem_we, a_mem_ack;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  // Instance B signals
  logic        b_rst, b_inst_req, b_inst_ack, b_inst_err, b_data_req, b_data_we, b_data_ack, b_data_err;
  logic [31:0] b_inst_addr, b_inst_data, b_data_addr, b_data_wdata, b_data_rdata;
  logic [2:0]  b_data_f3, b_mem_f3;
  logic        b_mem_req, b_mem_we, b_mem_ack;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(4), .DATA_PRIORITY(0)) dut_a (
    .i_clk(clk), .i_rst(a_rst),
    .i_inst_req(a_inst_req), .i_inst_addr(a_inst_addr),
    .o_inst_ack(a_inst_ack), .o_inst_data(a_inst_data), .o_inst_err(a_inst_err),
    .i_data_req(a_data_req), .i_data_addr(a_data_addr), .i_data_wdata(a_data_wdata),
    .i_data_funct3(a_data_f3), .i_data_we(a_data_we),
    .o_data_ack(a_data_ack), .o_data_rdata(a_data_rdata), .o_data_err(a_data_err),
    .o_mem_req(a_mem_req), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .o_mem_funct3(a_mem_f3), .o_mem_we(a_mem_we),
    .i_mem_ack(a_mem_ack), .i_mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(0), .DATA_PRIORITY(1)) dut_b (
    .i_clk(clk), .i_rst(b_rst),
    .i_inst_req(b_inst_req), .i_inst_addr(b_inst_addr),
    .o_inst_ack(b_inst_ack), .o_inst_data(b_inst_data), .o_inst_err(b_inst_err),
    .i_data_req(b_data_req), .i_data_addr(b_data_addr), .i_data_wdata(b_data_wdata),
    .i_data_funct3(b_data_f3), .i_data_we(b_data_we),
    .o_data_ack(b_data_ack), .o_data_rdata(b_data_rdata), .o_data_err(b_data_err),
    .o_mem_req(b_mem_req), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .o_mem_funct3(b_mem_f3), .o_mem_we(b_mem_we),
    .i_mem_ack(b_mem_ack), .i_mem_rdata(b_mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        we;
  } mreq_t;

  typedef struct {
    bit          is_inst;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  typedef struct {
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    bit          we;
    int          delay;
    logic [31:0] base;
  } vec_t;

  localparam logic [31:0] B_IADDR = 32'h0000_0040;
  localparam logic [31:0] B_DADDR = 32'h0000_0080;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mreq_t a_exp_mem[$];
  rsp_t  a_exp_rsp[$];
  bit    b_exp_inst[$];

  int          a_delay = 1;      // BUSY cycle in which memory acks; 0 = never
  logic [31:0] a_base  = '0;     // memory returns a_base ^ address
  int          a_busy  = 0;
  bit          a_stray = 1'b0;
  bit          a_prev_req = 1'b0;
  int          a_rise_cyc = 0;
  int          a_ack_cyc  = 0;
  logic [31:0] a_hold_inst = '0;
  logic [31:0] a_hold_data = '0;
  bit          rr_last_data = 1'b1;
  int          b_data_left = 0;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs at the falling edge, score them, then drive the memory models.
  task automatic tick();
    mreq_t m;
    rsp_t  r;
    bit    ei;
    @(negedge clk);
    cyc++;
    if (a_inst_ack || a_data_ack) begin
      a_ack_cyc = cyc;
      check("a_acks_exclusive", a_inst_ack & a_data_ack, 0);
      if (a_exp_rsp.size() == 0) begin
        check("a_unexpected_ack", {a_inst_ack, a_data_ack}, 0);
      end else begin
        r = a_exp_rsp.pop_front();
        if (r.is_inst) begin
          check("a_inst_rsp", {a_inst_ack, a_data_ack, a_inst_err, a_inst_data}, {1'b1, 1'b0, r.err, r.data});
          a_hold_inst = r.data;
        end else begin
          check("a_data_rsp", {a_data_ack, a_inst_ack, a_data_err, a_data_rdata}, {1'b1, 1'b0, r.err, r.data});
          a_hold_data = r.data;
        end
      end
      if (a_inst_ack) a_inst_req = 1'b0;
      if (a_data_ack) a_data_req = 1'b0;
    end else begin
      check("a_quiet_outputs", {a_inst_err, a_data_err, a_inst_data, a_data_rdata},
            {2'b00, a_hold_inst, a_hold_data});
    end
    if (a_mem_req && !a_prev_req) begin
      a_rise_cyc = cyc;
      if (a_exp_mem.size() == 0) begin
        check("a_unexpected_mem_req", a_mem_req, 0);
      end else begin
        m = a_exp_mem.pop_front();
        check("a_mem_fields", {a_mem_addr, a_mem_wdata, a_mem_f3, a_mem_we}, {m.addr, m.wdata, m.f3, m.we});
      end
    end
    a_prev_req = a_mem_req;
    if (a_mem_req) begin
      a_busy++;
      a_mem_ack   = (a_delay != 0) && (a_busy == a_delay);
      a_mem_rdata = a_mem_ack ? (a_base ^ a_mem_addr) : 32'h0BAD_0BAD;
    end else begin
      a_busy      = 0;
      a_mem_ack   = a_stray;
      a_mem_rdata = 32'h5555_AAAA;
    end

    if (b_inst_ack || b_data_ack) begin
      check("b_acks_exclusive", b_inst_ack & b_data_ack, 0);
      if (b_exp_inst.size() == 0) begin
        check("b_unexpected_ack", {b_inst_ack, b_data_ack}, 0);
      end else begin
        ei = b_exp_inst.pop_front();
        check("b_grant_order", {b_inst_ack, b_data_ack, (b_inst_ack ? b_inst_data : b_data_rdata)},
              {ei, !ei, (ei ? B_IADDR : B_DADDR)});
      end
      if (b_inst_ack) b_inst_req = 1'b0;
      if (b_data_ack) begin
        b_data_left--;
        if (b_data_left <= 0) b_data_req = 1'b0;
      end
    end
    b_mem_ack   = b_mem_req;
    b_mem_rdata = b_mem_addr;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((a_exp_rsp.size() + a_exp_mem.size() + b_exp_inst.size()) != 0 && n < 60) begin
      tick();
      n++;
    end
    check({name, "_completed"}, a_exp_rsp.size() + a_exp_mem.size() + b_exp_inst.size(), 0);
  endtask

  task automatic push_inst(input logic [31:0] addr, input logic [31:0] base);
    a_exp_mem.push_back('{addr: addr, wdata: 32'h0, f3: 3'b010, we: 1'b0});
    a_exp_rsp.push_back('{is_inst: 1'b1, data: base ^ addr, err: 1'b0});
  endtask

  task automatic push_data(input vec_t v, input bit timed_out);
    a_exp_mem.push_back('{addr: v.daddr, wdata: v.wdata, f3: v.f3, we: v.we});
    a_exp_rsp.push_back('{is_inst: 1'b0, data: (timed_out ? 32'h0 : (v.base ^ v.daddr)), err: timed_out});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int req_cyc;
    vec_t v;

    vecs[0] = '{ireq: 1, iaddr: 32'h8,   dreq: 1, daddr: 32'h100, wdata: 32'hDEAD_BEEF, f3: 3'b010, we: 1, delay: 1, base: 32'h1111_0000};
    vecs[1] = '{ireq: 1, iaddr: 32'h4,   dreq: 0, daddr: 32'h0,   wdata: 32'h0,         f3: 3'b000, we: 0, delay: 2, base: 32'h0010_0097};
    vecs[2] = '{ireq: 1, iaddr: 32'hC,   dreq: 1, daddr: 32'h104, wdata: 32'h1234_5678, f3: 3'b001, we: 0, delay: 3, base: 32'h2222_2222};
    vecs[3] = '{ireq: 0, iaddr: 32'h0,   dreq: 1, daddr: 32'h200, wdata: 32'h0,         f3: 3'b100, we: 0, delay: 1, base: 32'h3333_0000};
    vecs[4] = '{ireq: 1, iaddr: 32'h10,  dreq: 1, daddr: 32'h108, wdata: 32'h0000_00AB, f3: 3'b000, we: 1, delay: 2, base: 32'h4444_4444};
    vecs[5] = '{ireq: 0, iaddr: 32'h0,   dreq: 1, daddr: 32'h10C, wdata: 32'hCAFE_F00D, f3: 3'b001, we: 1, delay: 4, base: 32'h5555_0000};

    a_rst = 1'b1; b_rst = 1'b1;
    a_inst_req = 0; a_inst_addr = '0; a_data_req = 0; a_data_addr = '0; a_data_wdata = '0; a_data_f3 = '0; a_data_we = 0;
    b_inst_req = 0; b_inst_addr = B_IADDR; b_data_req = 0; b_data_addr = B_DADDR; b_data_wdata = '0; b_data_f3 = 3'b010; b_data_we = 0;
    a_mem_ack = 0; a_mem_rdata = '0; b_mem_ack = 0; b_mem_rdata = '0;
    tick();
    tick();
    check("a_reset_state", {a_mem_req, a_mem_addr, a_mem_wdata, a_mem_f3, a_mem_we, a_inst_ack, a_inst_err, a_data_ack, a_data_err}, 0);
    check("b_reset_state", {b_mem_req, b_mem_addr, b_inst_ack, b_data_ack, b_inst_data, b_data_rdata}, 0);
    a_rst = 1'b0; b_rst = 1'b0;
    rr_last_data = 1'b1;
    tick();

    // Table-driven transactions on the round-robin instance.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      a_delay = v.delay;
      a_base  = v.base;
      if (v.ireq && v.dreq) begin
        if (rr_last_data) begin
          push_inst(v.iaddr, v.base); push_data(v, 1'b0); rr_last_data = 1'b1;
        end else begin
          push_data(v, 1'b0); push_inst(v.iaddr, v.base); rr_last_data = 1'b0;
        end
      end else if (v.ireq) begin
        push_inst(v.iaddr, v.base); rr_last_data = 1'b0;
      end else begin
        push_data(v, 1'b0); rr_last_data = 1'b1;
      end
      a_inst_req = v.ireq; a_inst_addr = v.iaddr;
      a_data_req = v.dreq; a_data_addr = v.daddr; a_data_wdata = v.wdata; a_data_f3 = v.f3; a_data_we = v.we;
      req_cyc = cyc;
      drain($sformatf("vec%0d", i));
      if (!(v.ireq && v.dreq)) begin
        check($sformatf("vec%0d_latency", i), {a_rise_cyc - req_cyc, a_ack_cyc - a_rise_cyc}, {32'd1, v.delay});
      end
      tick();
    end

    // Memory never acks a load: watchdog ends it after four BUSY cycles.
    v = '{ireq: 0, iaddr: 32'h0, dreq: 1, daddr: 32'h300, wdata: 32'h0, f3: 3'b010, we: 0, delay: 0, base: 32'h0};
    a_delay = 0;
    push_data(v, 1'b1); rr_last_data = 1'b1;
    a_data_req = 1; a_data_addr = v.daddr; a_data_wdata = v.wdata; a_data_f3 = v.f3; a_data_we = v.we;
    req_cyc = cyc;
    drain("timeout");
    check("timeout_latency", {a_rise_cyc - req_cyc, a_ack_cyc - a_rise_cyc}, {32'd1, 32'd4});
    tick();
    tick();

    // Asynchronous reset while a fetch is outstanding, then re-grant after release.
    a_delay = 0;
    a_inst_req = 1; a_inst_addr = 32'h44;
    push_inst(32'h44, 32'h0);
    tick();
    tick();
    check("busy_before_reset", a_mem_req, 1);
    #2 a_rst = 1'b1;
    #1;
    check("async_reset_outputs", {a_mem_req, a_inst_ack, a_data_ack, a_inst_err, a_data_err, a_inst_data, a_data_rdata, a_mem_addr}, 0);
    a_exp_mem.delete();
    a_exp_rsp.delete();
    a_hold_inst = '0;
    a_hold_data = '0;
    a_prev_req  = 1'b0;
    rr_last_data = 1'b1;
    tick();
    a_rst = 1'b0;
    a_delay = 1;
    a_base  = 32'h6666_0000;
    push_inst(32'h44, a_base); rr_last_data = 1'b0;
    req_cyc = cyc;
    drain("regrant_after_reset");
    check("regrant_latency", {a_rise_cyc - req_cyc, a_ack_cyc - a_rise_cyc}, {32'd1, 32'd1});
    tick();

    // Stray memory acks while idle are ignored.
    a_stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_ack_idle", {a_mem_req, a_inst_ack, a_data_ack}, 0);
    end
    a_stray = 1'b0;
    tick();
    a_delay = 2; a_base = 32'h7777_0000;
    push_inst(32'h48, a_base); rr_last_data = 1'b0;
    a_inst_req = 1; a_inst_addr = 32'h48;
    req_cyc = cyc;
    drain("fetch_after_stray");
    check("fetch_after_stray_latency", {a_rise_cyc - req_cyc, a_ack_cyc - a_rise_cyc}, {32'd1, 32'd2});
    tick();

    // Data-priority instance: data re-requests three times while a fetch waits.
    b_data_left = 3;
    b_exp_inst.push_back(1'b0);
    b_exp_inst.push_back(1'b0);
    b_exp_inst.push_back(1'b0);
    b_exp_inst.push_back(1'b1);
    b_inst_req = 1;
    b_data_req = 1;
    drain("data_priority");
    tick();
    check("b_no_err", {b_inst_err, b_data_err, b_mem_req}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
